// File: rtl/result_writeback_arbiter.sv
// result_writeback_arbiter
//   Collects results from the ADD, MULT and MULADD execution units and
//   serialises them onto one register-file writeback port.
//
//   Each unit has a private 2-entry FIFO of {data, dest}.
//   A round-robin arbiter drains the FIFOs into one registered writeback
//   stage. That stage holds its contents until the consumer accepts them.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   <unit>_valid/ready          producer handshake, one pair per unit
//   <unit>_data/dest            result value and destination register tag
//   wb_valid/wb_ready           writeback handshake towards the register file
//   wb_data/wb_dest/wb_unit     held result, its tag and its originating unit code
//   busy                        any FIFO non-empty or writeback stage occupied
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready.
//   - Producer side: ready depends only on the FIFO count, never on valid.
//   - Writeback side: while wb_valid && !wb_ready, wb_data, wb_dest and
//     wb_unit hold steady and no FIFO is popped.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module result_writeback_arbiter #(
  parameter int         WORD_SIZE  = `WORD_SIZE,
  parameter int         REG_ADDR_W = 5,
  parameter logic [1:0] ADD        = 2'b00,
  parameter logic [1:0] MULT       = 2'b01,
  parameter logic [1:0] MULADD     = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add_valid,
  output logic                  add_ready,
  input  logic [WORD_SIZE-1:0]  add_data,
  input  logic [REG_ADDR_W-1:0] add_dest,
  input  logic                  mult_valid,
  output logic                  mult_ready,
  input  logic [WORD_SIZE-1:0]  mult_data,
  input  logic [REG_ADDR_W-1:0] mult_dest,
  input  logic                  muladd_valid,
  output logic                  muladd_ready,
  input  logic [WORD_SIZE-1:0]  muladd_data,
  input  logic [REG_ADDR_W-1:0] muladd_dest,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [WORD_SIZE-1:0]  wb_data,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [1:0]            wb_unit,
  output logic                  busy
);

  // Internal index per unit: 0 = ADD, 1 = MULT, 2 = MULADD.
  logic [2:0]            in_valid;
  logic [WORD_SIZE-1:0]  in_data [3];
  logic [REG_ADDR_W-1:0] in_dest [3];

  assign in_valid   = {muladd_valid, mult_valid, add_valid};
  assign in_data[0] = add_data;
  assign in_data[1] = mult_data;
  assign in_data[2] = muladd_data;
  assign in_dest[0] = add_dest;
  assign in_dest[1] = mult_dest;
  assign in_dest[2] = muladd_dest;

  logic [WORD_SIZE-1:0]  mem_data [3][2];
  logic [REG_ADDR_W-1:0] mem_dest [3][2];
  logic [1:0]            count    [3];
  logic                  wr_ptr   [3];
  logic                  rd_ptr   [3];

  logic [2:0] full, nonempty, push, pop;
  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       out_free;

  assign out_free = !wb_valid || wb_ready;

  // A full FIFO refuses a push even when it pops in the same cycle.
  // There is no bypass path.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    pop      = '0;
    for (int i = 0; i < 3; i++) begin
      full[i]     = (count[i] == 2'd2);
      nonempty[i] = (count[i] != 2'd0);
      push[i]     = in_valid[i] && !full[i];
      pop[i]      = grant_valid && (grant_idx == 2'(i));
    end
  end

  assign add_ready    = !full[0];
  assign mult_ready   = !full[1];
  assign muladd_ready = !full[2];

  // Round robin: priority starts at the unit after last_grant.
  always_comb begin
    grant_valid = out_free && (|nonempty);
    grant_idx   = 2'd0;
    case (last_grant)
      2'd0:    grant_idx = nonempty[1] ? 2'd1 : (nonempty[2] ? 2'd2 : 2'd0);
      2'd1:    grant_idx = nonempty[2] ? 2'd2 : (nonempty[0] ? 2'd0 : 2'd1);
      default: grant_idx = nonempty[0] ? 2'd0 : (nonempty[1] ? 2'd1 : 2'd2);
    endcase
  end

  // FIFO storage: data registers need no reset because
  // count gates every read of them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) begin
        mem_data[i][wr_ptr[i]] <= in_data[i];
        mem_dest[i][wr_ptr[i]] <= in_dest[i];
      end
    end
  end

  // FIFO counts and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        count[i]  <= 2'd0;
        wr_ptr[i] <= 1'b0;
        rd_ptr[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        count[i] <= count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
        if (push[i]) wr_ptr[i] <= !wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= !rd_ptr[i];
      end
    end
  end

  // Writeback stage and arbitration history.
  // last_grant resets to MULADD so that ADD is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_dest    <= '0;
      wb_unit    <= 2'b00;
      last_grant <= 2'd2;
    end else if (grant_valid) begin
      wb_valid   <= 1'b1;
      wb_data    <= mem_data[grant_idx][rd_ptr[grant_idx]];
      wb_dest    <= mem_dest[grant_idx][rd_ptr[grant_idx]];
      case (grant_idx)
        2'd0:    wb_unit <= ADD;
        2'd1:    wb_unit <= MULT;
        default: wb_unit <= MULADD;
      endcase
      last_grant <= grant_idx;
    end else if (out_free) begin
      wb_valid <= 1'b0;
    end
  end

  assign busy = (|nonempty) || wb_valid;

endmodule

// File: tb/tb_result_writeback_arbiter.sv
module tb_result_writeback_arbiter;

  localparam int W = 32;
  localparam int A = 5;

  logic          clk;
  logic          rst;
  logic [2:0]    v;
  wire  [2:0]    rdy;
  logic [W-1:0]  d  [3];
  logic [A-1:0]  ds [3];
  logic          wb_valid;
  logic          wb_ready;
  logic [W-1:0]  wb_data;
  logic [A-1:0]  wb_dest;
  logic [1:0]    wb_unit;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one expected queue per unit, entries {dest, data}.
  logic [A+W-1:0] exp_q_add[$];
  logic [A+W-1:0] exp_q_mult[$];
  logic [A+W-1:0] exp_q_muladd[$];
  logic [1:0]     grant_q[$];
  bit             log_grants = 0;

  result_writeback_arbiter #(.WORD_SIZE(W), .REG_ADDR_W(A)) dut (
    .clk(clk), .rst(rst),
    .add_valid(v[0]), .add_ready(rdy[0]), .add_data(d[0]), .add_dest(ds[0]),
    .mult_valid(v[1]), .mult_ready(rdy[1]), .mult_data(d[1]), .mult_dest(ds[1]),
    .muladd_valid(v[2]), .muladd_ready(rdy[2]), .muladd_data(d[2]), .muladd_dest(ds[2]),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_unit(wb_unit), .busy(busy)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: samples on the falling edge, where inputs and outputs are settled.
  logic           hold_prev = 1'b0;
  logic [W+A+1:0] prev_out;

  always @(negedge clk) begin
    logic [A+W-1:0] exp_e, got_e;
    bit have;
    if (rst) begin
      exp_q_add.delete();
      exp_q_mult.delete();
      exp_q_muladd.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if ({wb_valid, wb_data, wb_dest, wb_unit} !== {1'b1, prev_out}) begin
          errors++;
          $display("FAIL wb_stable got %h exp %h", {wb_data, wb_dest, wb_unit}, prev_out);
        end
      end
      if (v[0] && rdy[0]) exp_q_add.push_back({ds[0], d[0]});
      if (v[1] && rdy[1]) exp_q_mult.push_back({ds[1], d[1]});
      if (v[2] && rdy[2]) exp_q_muladd.push_back({ds[2], d[2]});
      if (wb_valid && wb_ready) begin
        checks++;
        have  = 0;
        exp_e = '0;
        got_e = {wb_dest, wb_data};
        case (wb_unit)
          2'b00: if (exp_q_add.size() > 0)    begin exp_e = exp_q_add.pop_front();    have = 1; end
          2'b01: if (exp_q_mult.size() > 0)   begin exp_e = exp_q_mult.pop_front();   have = 1; end
          2'b10: if (exp_q_muladd.size() > 0) begin exp_e = exp_q_muladd.pop_front(); have = 1; end
          default: have = 0;
        endcase
        if (!have) begin
          errors++;
          $display("FAIL sb_unexpected unit %0d got %h exp none", wb_unit, got_e);
        end else if (got_e !== exp_e) begin
          errors++;
          $display("FAIL sb_data unit %0d got %h exp %h", wb_unit, got_e, exp_e);
        end
        if (log_grants) grant_q.push_back(wb_unit);
      end
      hold_prev = wb_valid && !wb_ready;
      prev_out  = {wb_data, wb_dest, wb_unit};
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Holds valid until the result is accepted; returns just after the accepting edge.
  task automatic push_one(input int u, input logic [W-1:0] data, input logic [A-1:0] dest);
    int n;
    v[u]  = 1'b1;
    d[u]  = data;
    ds[u] = dest;
    n = 0;
    while (!rdy[u] && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL push_timeout unit %0d got ready=0 exp ready=1", u);
    end
    step();
    v[u] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s drain busy got %b exp 0", name, busy);
    end
  endtask

  task automatic check_wb(input string name, input logic exp_v, input logic [W-1:0] exp_d,
                          input logic [A-1:0] exp_ds, input logic [1:0] exp_u);
    checks++;
    if ({wb_valid, wb_data, wb_dest, wb_unit} !== {exp_v, exp_d, exp_ds, exp_u}) begin
      errors++;
      $display("FAIL %s got v=%b d=%h dest=%0d u=%0d exp v=%b d=%h dest=%0d u=%0d",
               name, wb_valid, wb_data, wb_dest, wb_unit, exp_v, exp_d, exp_ds, exp_u);
    end
  endtask

  // Tests
  task automatic test_reset();
    v = '0;
    wb_ready = 1'b0;
    rst = 1'b1;
    #3;
    check_wb("reset_outputs", 1'b0, '0, '0, 2'b00);
    checks++;
    if ({busy, rdy} !== 4'b0111) begin
      errors++;
      $display("FAIL reset_busy_ready got %b exp 0111", {busy, rdy});
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({wb_valid, busy, rdy} !== 5'b00111) begin
      errors++;
      $display("FAIL reset_release got %b exp 00111", {wb_valid, busy, rdy});
    end
  endtask

  task automatic test_single();
    do_reset();
    wb_ready = 1'b1;
    push_one(0, 32'h0000_00AA, 5'd3);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early got %b exp 0", wb_valid);
    end
    step();
    check_wb("single_out", 1'b1, 32'hAA, 5'd3, 2'b00);
    step();
    checks++;
    if ({wb_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_drain got %b exp 00", {wb_valid, busy});
    end
  endtask

  task automatic test_all_three();
    logic [W-1:0] ed [3];
    ed[0] = 32'h11;
    ed[1] = 32'h22;
    ed[2] = 32'h33;
    do_reset();
    wb_ready = 1'b1;
    v = 3'b111;
    for (int u = 0; u < 3; u++) begin
      d[u]  = ed[u];
      ds[u] = A'(u + 1);
    end
    step();
    v = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_wb("all_three_order", 1'b1, ed[k], A'(k + 1), 2'(k));
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL all_three_busy_last got %b exp 1", busy);
    end
    step();
    checks++;
    if ({wb_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL all_three_idle got %b exp 00", {wb_valid, busy});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    wb_ready = 1'b0;
    push_one(1, 32'h101, 5'd4);
    push_one(1, 32'h102, 5'd5);
    push_one(1, 32'h103, 5'd6);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_mult_ready got %b exp 0", rdy[1]);
      end
      check_wb("bp_hold", 1'b1, 32'h101, 5'd4, 2'b01);
      step();
    end
    wb_ready = 1'b1;
    step();
    check_wb("bp_second", 1'b1, 32'h102, 5'd5, 2'b01);
    step();
    check_wb("bp_third", 1'b1, 32'h103, 5'd6, 2'b01);
    step();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got %b exp 0", wb_valid);
    end
  endtask

  task automatic test_fairness();
    int cnt [3];
    bit acc [3];
    do_reset();
    wb_ready = 1'b1;
    grant_q.delete();
    log_grants = 1;
    for (int u = 0; u < 3; u++) cnt[u] = 0;
    for (int c = 0; c < 9; c++) begin
      for (int u = 0; u < 3; u++) begin
        v[u]   = 1'b1;
        d[u]   = 32'h1000 * (u + 1) + cnt[u];
        ds[u]  = A'(cnt[u]);
        acc[u] = rdy[u];
      end
      step();
      for (int u = 0; u < 3; u++) if (acc[u]) cnt[u]++;
    end
    v = '0;
    wait_idle("fairness");
    log_grants = 0;
    checks++;
    if (grant_q.size() < 9) begin
      errors++;
      $display("FAIL fairness_count got %0d exp >=9", grant_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (grant_q[i] !== 2'(i % 3)) begin
          errors++;
          $display("FAIL fairness_seq[%0d] got %0d exp %0d", i, grant_q[i], i % 3);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    wb_ready = 1'b0;
    push_one(0, 32'hA1, 5'd1);
    push_one(0, 32'hA2, 5'd2);
    push_one(0, 32'hA3, 5'd3);
    push_one(1, 32'hB1, 5'd4);
    push_one(1, 32'hB2, 5'd5);
    checks++;
    if ({wb_valid, rdy} !== 4'b1100) begin
      errors++;
      $display("FAIL mid_precondition got %b exp 1100", {wb_valid, rdy});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wb_valid, busy, rdy} !== 5'b00111) begin
      errors++;
      $display("FAIL mid_reset_immediate got %b exp 00111", {wb_valid, busy, rdy});
    end
    step();
    rst = 1'b0;
    wb_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (wb_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_stale_output got %0d exp 0", seen);
    end
  endtask

  task automatic test_random();
    bit held [3];
    do_reset();
    for (int u = 0; u < 3; u++) held[u] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int u = 0; u < 3; u++) begin
        if (!held[u]) begin
          v[u]  = 1'($urandom_range(0, 1));
          d[u]  = $urandom;
          ds[u] = A'($urandom_range(0, 31));
        end
      end
      wb_ready = 1'($urandom_range(0, 1));
      for (int u = 0; u < 3; u++) held[u] = v[u] && !rdy[u];
      step();
    end
    v = '0;
    wb_ready = 1'b1;
    wait_idle("random");
    checks++;
    if (exp_q_add.size() + exp_q_mult.size() + exp_q_muladd.size() != 0) begin
      errors++;
      $display("FAIL random_leftover got %0d exp 0",
               exp_q_add.size() + exp_q_mult.size() + exp_q_muladd.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    v = '0;
    wb_ready = 1'b0;
    for (int u = 0; u < 3; u++) begin
      d[u]  = '0;
      ds[u] = '0;
    end
    test_reset();
    test_single();
    test_all_three();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_writeback_arbiter.md
# result_writeback_arbiter

Collects results returning from the ADD, MULT and MULADD execution units and serialises them onto a single register-file writeback port; it is the return path for operands steered into the unit containers by the source-value muxes. Each unit feeds a private 2-entry FIFO through a valid/ready handshake. A round-robin arbiter drains the FIFOs into one registered writeback stage that holds until the consumer accepts.

## Interface
- WORD_SIZE, default `WORD_SIZE (32): result data width
- REG_ADDR_W, default 5: destination register tag width
- ADD / MULT / MULADD, default 2'b00 / 2'b01 / 2'b10: unit codes driven on wb_unit
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- add_valid / mult_valid / muladd_valid  input  1 each  unit presents a result
- add_ready / mult_ready / muladd_ready  output  1 each  FIFO of that unit has a free slot
- add_data / mult_data / muladd_data  input  WORD_SIZE each  result value
- add_dest / mult_dest / muladd_dest  input  REG_ADDR_W each  destination register tag
- wb_valid  output  1  writeback register holds a result
- wb_ready  input  1  register file accepts the result this cycle
- wb_data  output  WORD_SIZE  result value
- wb_dest  output  REG_ADDR_W  destination tag
- wb_unit  output  2  originating unit code
- busy  output  1  any FIFO non-empty or wb_valid high

## Operation
- Per unit: 2-entry FIFO of {data, dest} with a 2-bit count (0..2) and read/write pointers.
- x_ready = (count_x != 2), combinational from count only. It does not depend on x_valid or wb_ready.
- Push when x_valid && x_ready. A full FIFO accepts nothing, even if it pops in the same cycle; there is no bypass.
- Output stage is free when !wb_valid || wb_ready.
- When the output stage is free and at least one FIFO is non-empty:
  - grant one unit by round robin;
  - pop its head into wb_data / wb_dest / wb_unit;
  - set wb_valid = 1.
- When the output stage is free and all FIFOs are empty, wb_valid goes to 0.
- Round robin: last_grant register. Priority order starts at the unit after last_grant (ADD -> MULT -> MULADD -> ADD). last_grant updates only on a grant.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged. Data order is FIFO.
- Handshake rule: while wb_valid && !wb_ready, wb_data, wb_dest and wb_unit are stable and no pop occurs.
- Results from one unit leave in arrival order. There is no ordering guarantee across units.
- No data is dropped. Producers must hold x_data and x_dest stable while x_valid && !x_ready.

## Timing
- Reset (async assert) gives:
  - all FIFO counts and pointers 0;
  - last_grant = MULADD, so ADD has first priority;
  - wb_valid = 0, wb_data = 0, wb_dest = 0, wb_unit = 2'b00;
  - busy = 0, and all x_ready = 1 while rst is high and after release.
- Reset asserted mid-operation discards all queued and held results immediately. Nothing is output after release until new pushes arrive.
- Latency: a result accepted at edge N is in its FIFO after N. If it wins arbitration, wb_valid is high after edge N+1. Minimum latency is 2 edges with no idle bubble.
- Throughput: one writeback per cycle aggregate while wb_ready = 1 and any FIFO is non-empty.
- Fairness: with all three FIFOs continuously non-empty and wb_ready = 1, grants cycle ADD, MULT, MULADD, ADD, ...
- Backpressure: with wb_ready = 0, each FIFO fills to 2 and then its x_ready drops. After that, up to 7 results are held in total: 3 × 2 in the FIFOs plus 1 in the output stage.

## Test plan
- Reset, then a single push add_data=0x0000_00AA, add_dest=3 at edge N -> wb_valid=1 after edge N+1 with wb_data=0xAA, wb_dest=3, wb_unit=00; with wb_ready=1, wb_valid=0 after edge N+2.
- All three units push in the same cycle (0x11/d1, 0x22/d2, 0x33/d3), wb_ready=1 -> writebacks in order 0x11/00, 0x22/01, 0x33/10 on consecutive cycles; busy falls after the last.
- Hold wb_ready=0 and push 3 results into MULT -> mult_ready=0 after the third acceptance (1 in the output stage, 2 in the FIFO); wb_data stays stable. Release wb_ready -> all 3 results emerge in arrival order.
- Continuous valid on all units for 9 cycles with wb_ready=1 -> wb_unit sequence 00,01,10 repeated 3 times; no result lost or duplicated (scoreboard).
- Assert rst while wb_valid=1 and the FIFOs hold 4 results -> wb_valid=0, busy=0 and all x_ready=1 immediately; no stale result appears after release.
- Random valid and wb_ready at 50% for 2000 cycles -> scoreboard matches per-unit order; wb outputs are never changed while wb_valid && !wb_ready.
